// File: rtl/mac_accum_ctrl.sv
// ----------------------------------------------------------------------------
// mac_accum_ctrl
//
// Accumulates N unsigned 12-bit MAC partial results into a 14-bit sum and
// presents the scaled result (sum bits [11:4]) on a valid/ready output port.
// The block alternates between two states:
//   ACC  : accepts inputs (in_ready = 1) until N transfers have been summed.
//   HOLD : presents the result (out_valid = 1) until the consumer takes it.
// No input is accepted while in HOLD, including the handshake cycle.
//
// Optional feature (compile-time macro):
//   MAC_ACCUM_SATURATE_EN - out_data reads 0xFF whenever sum bits [13:12]
//                           are nonzero; otherwise the result wraps/truncates.
//
// Parameters:
//   N          partial results per output, legal range 1..4
//
// Ports:
//   clk        single clock, all state changes on rising edge
//   rst        synchronous active-high reset (highest priority)
//   clear      synchronous abort of the current group (beats handshakes)
//   in_valid   in_data holds a valid partial result
//   in_ready   block accepts in_data this cycle
//   in_data    12-bit unsigned partial result
//   out_valid  out_data holds a completed result
//   out_ready  consumer takes out_data this cycle
//   out_data   8-bit scaled result
//   count      inputs accepted in the current group
// ----------------------------------------------------------------------------
module mac_accum_ctrl #(
    parameter int N = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic [2:0]  count
);

    localparam logic [0:0] ACC  = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0]  state;
    logic [13:0] acc;
    logic [2:0]  count_next;
    logic        transfer;
    logic        handshake;

    assign in_ready   = (state == ACC);
    assign out_valid  = (state == HOLD);
    assign transfer   = in_valid  & in_ready;
    assign handshake  = out_valid & out_ready;
    assign count_next = count + 3'd1;

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values of the others; blocking here would create ordering
    // dependent behaviour between acc, count and state.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            // rst is listed first in the condition but both have the same
            // effect; either one overrides any simultaneous handshake.
            state <= ACC;
            acc   <= '0;
            count <= '0;
        end else begin
            case (state)
                ACC: begin
                    if (transfer) begin
                        acc   <= acc + {2'b00, in_data};
                        count <= count_next;
                        if (count_next == 3'(N))
                            state <= HOLD;
                    end
                end
                HOLD: begin
                    if (handshake) begin
                        state <= ACC;
                        acc   <= '0;
                        count <= '0;
                    end
                end
                default: begin
                    state <= ACC;
                    acc   <= '0;
                    count <= '0;
                end
            endcase
        end
    end

    // Result is a pure function of the stored sum, so it stays stable for as
    // long as HOLD lasts.
`ifdef MAC_ACCUM_SATURATE_EN
    assign out_data = (acc[13:12] != 2'b00) ? 8'hFF : acc[11:4];
`else
    assign out_data = acc[11:4];
`endif

endmodule

// File: tb/tb_mac_accum_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mac_accum_ctrl
//
// Drives three instances (N = 1, 2, 4) from shared stimulus and compares each
// against a group-level reference: a running sum, an accepted-item tally and
// a "result pending" flag, updated from the handshake rules. Directed
// scenarios cover the worked examples; a randomized phase follows.
// ----------------------------------------------------------------------------
module tb_mac_accum_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        in_valid;
    logic [11:0] in_data;
    logic        out_ready;

    logic [2:0]      ir;
    logic [2:0]      ov;
    logic [2:0][7:0] od;
    logic [2:0][2:0] cnt;

    int checks = 0;
    int errors = 0;

    // Reference state per instance
    int ns       [3] = '{1, 2, 4};
    int m_sum    [3];
    int m_items  [3];
    bit m_pending[3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mac_accum_ctrl #(.N((g == 0) ? 1 : (g == 1) ? 2 : 4)) u_dut (
            .clk      (clk),
            .rst      (rst),
            .clear    (clear),
            .in_valid (in_valid),
            .in_ready (ir[g]),
            .in_data  (in_data),
            .out_valid(ov[g]),
            .out_ready(out_ready),
            .out_data (od[g]),
            .count    (cnt[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] scaled(input int sum);
`ifdef MAC_ACCUM_SATURATE_EN
        if (sum >= 4096) return 8'hFF;
`endif
        return 8'((sum / 16) % 256);
    endfunction

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("n%0d in_ready", ns[k]),  32'(ir[k]),  32'(!m_pending[k]));
            check($sformatf("n%0d out_valid", ns[k]), 32'(ov[k]),  32'(m_pending[k]));
            check($sformatf("n%0d count", ns[k]),     32'(cnt[k]), 32'(m_items[k]));
            check($sformatf("n%0d out_data", ns[k]),  32'(od[k]),  32'(scaled(m_sum[k])));
        end
    endtask

    // One clock: drive at negedge, reference update at posedge, compare at
    // the following negedge.
    task automatic cycle(input bit r, input bit c, input bit v,
                         input logic [11:0] d, input bit o);
        rst = r; clear = c; in_valid = v; in_data = d; out_ready = o;
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (r || c) begin
                m_sum[k] = 0; m_items[k] = 0; m_pending[k] = 0;
            end else if (!m_pending[k]) begin
                if (v) begin
                    m_sum[k]   += int'(d);
                    m_items[k] += 1;
                    if (m_items[k] == ns[k]) m_pending[k] = 1;
                end
            end else if (o) begin
                m_sum[k] = 0; m_items[k] = 0; m_pending[k] = 0;
            end
        end
        @(negedge clk);
        check_all();
    endtask

    initial begin
        logic [7:0] big_exp;
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        @(negedge clk);

        // Reset state
        cycle(1, 0, 0, 12'h000, 0);
        cycle(1, 0, 1, 12'hFFF, 1);
        check("rst in_ready", 32'(ir[2]), 32'd1);
        check("rst out_data", 32'(od[2]), 32'h00);

        // N=2 back-to-back pair, latency 1, then return to ACC
        cycle(0, 0, 1, 12'h100, 1);
        cycle(0, 0, 1, 12'h0F0, 1);
        check("pair out_valid", 32'(ov[1]), 32'd1);
        check("pair out_data",  32'(od[1]), 32'h1F);
        cycle(0, 0, 0, 12'h000, 1);
        check("pair back count", 32'(cnt[1]), 32'd0);
        check("pair back ready", 32'(ir[1]),  32'd1);

        // N=4 sum 0x2000: wraps to 0x00 or saturates to 0xFF
        cycle(1, 0, 0, 12'h000, 0);
        repeat (4) cycle(0, 0, 1, 12'h800, 0);
`ifdef MAC_ACCUM_SATURATE_EN
        big_exp = 8'hFF;
`else
        big_exp = 8'h00;
`endif
        check("big out_valid", 32'(ov[2]), 32'd1);
        check("big out_data",  32'(od[2]), 32'(big_exp));

        // Back-pressure: HOLD persists, nothing consumed, next group from 0
        repeat (5) cycle(0, 0, 1, 12'h123, 0);
        check("stall in_ready", 32'(ir[2]),  32'd0);
        check("stall out_data", 32'(od[2]),  32'(big_exp));
        check("stall count",    32'(cnt[2]), 32'd4);
        cycle(0, 0, 1, 12'h123, 1);
        check("release count", 32'(cnt[2]), 32'd0);
        cycle(0, 0, 1, 12'h030, 0);
        check("restart count", 32'(cnt[2]), 32'd1);

        // clear mid-group discards the simultaneous input
        cycle(1, 0, 0, 12'h000, 0);
        cycle(0, 0, 1, 12'h010, 0);
        cycle(0, 0, 1, 12'h020, 0);
        cycle(0, 1, 1, 12'h040, 0);
        check("clear count", 32'(cnt[2]), 32'd0);
        repeat (4) cycle(0, 0, 1, 12'h010, 0);
        check("after clear out_data", 32'(od[2]), 32'h04);

        // rst in HOLD beats the handshake
        cycle(1, 0, 0, 12'h000, 1);
        check("rst hold out_valid", 32'(ov[2]),  32'd0);
        check("rst hold out_data",  32'(od[2]),  32'h00);
        check("rst hold in_ready",  32'(ir[2]),  32'd1);
        check("rst hold count",     32'(cnt[2]), 32'd0);

        // N=1 with continuous in_valid: one accept every two cycles
        cycle(0, 0, 1, 12'h0A0, 1);
        check("n1 first data", 32'(od[0]), 32'h0A);
        cycle(0, 0, 1, 12'h0B0, 1);
        check("n1 bubble ready", 32'(ir[0]), 32'd1);
        cycle(0, 0, 1, 12'h0B0, 1);
        check("n1 second data", 32'(od[0]), 32'h0B);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            bit          r, c, v, o;
            logic [11:0] d;
            r = ($urandom_range(0, 99) == 0);
            c = ($urandom_range(0, 39) == 0);
            v = ($urandom_range(0, 9) < 7);
            o = ($urandom_range(0, 9) < 6);
            d = ($urandom_range(0, 3) == 0) ? 12'hFFF : 12'($urandom);
            cycle(r, c, v, d, o);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_accum_ctrl.md
MAC_ACCUM_CTRL -- requirements
Module: mac_accum_ctrl

Interface
REQ-001 SHALL have parameter N, default 4, number of MAC partial results accumulated per output; legal range 1..4.
REQ-002 SHALL have ports clk (input, 1 bit): single clock; all state changes on its rising edge.
REQ-003 SHALL have ports rst (input, 1 bit): synchronous, active-high reset.
REQ-004 SHALL have ports clear (input, 1 bit): synchronous abort of the current accumulation.
REQ-005 SHALL have ports in_valid (input, 1 bit): in_data holds a valid 12-bit MAC result.
REQ-006 SHALL have ports in_ready (output, 1 bit): block accepts in_data this cycle.
REQ-007 SHALL have ports in_data (input, 12 bits): unsigned MAC partial result.
REQ-008 SHALL have ports out_valid (output, 1 bit): out_data holds a completed result.
REQ-009 SHALL have ports out_ready (input, 1 bit): consumer takes out_data this cycle.
REQ-010 SHALL have ports out_data (output, 8 bits): scaled result.
REQ-011 SHALL have ports count (output, 3 bits): number of inputs accepted in the current group.

Function
REQ-012 SHALL implement states ACC and HOLD; in_ready = 1 only in ACC; out_valid = 1 only in HOLD.
REQ-013 Transfer SHALL occur on a cycle with in_valid & in_ready; each transfer SHALL add zero-extended in_data to a 14-bit unsigned accumulator and increment count.
REQ-014 The transfer that makes count reach N SHALL move state to HOLD on the next edge; out_valid SHALL be asserted the cycle after the last transfer (latency 1).
REQ-015 out_data SHALL be combinationally derived from the final accumulator as bits [11:4]; it SHALL be stable while out_valid is high.
REQ-016 In HOLD, out_valid & out_ready SHALL clear accumulator and count to 0 and return to ACC on the next edge; with out_ready low, HOLD SHALL persist indefinitely.
REQ-017 No input SHALL be accepted in HOLD, including the cycle of the out_ready handshake (no bypass).
REQ-018 in_valid low in ACC SHALL leave accumulator and count unchanged; gaps between transfers are allowed.
REQ-019 clear SHALL force accumulator = 0, count = 0, state = ACC on the next edge from any state, discarding any pending output; clear SHALL take priority over any simultaneous transfer or out handshake.
REQ-020 With N = 1 every transfer SHALL produce an output.
REQ-021 Accumulator SHALL never overflow for legal N (4 x 0xFFF = 0x3FFC < 2^14).

Reset
REQ-022 rst SHALL, on the next edge, set state = ACC, accumulator = 0, count = 0; hence in_ready = 1, out_valid = 0, out_data = 0x00.
REQ-023 rst SHALL take priority over clear and all handshakes, including mid-group and in HOLD.

Configuration
REQ-024 Macro MAC_ACCUM_SATURATE_EN defined: out_data SHALL be 0xFF whenever accumulator bits [13:12] are nonzero, else bits [11:4].
REQ-025 Macro MAC_ACCUM_SATURATE_EN undefined: out_data SHALL be accumulator bits [11:4] unconditionally (wrap/truncate).

Verification
REQ-026 N=2, transfers 0x100 then 0x0F0 back to back, out_ready=1 -> out_valid one cycle after 2nd transfer, out_data = 0x1F, then ACC with count = 0.
REQ-027 N=4, four transfers of 0x800 -> accumulator 0x2000; out_data = 0x00 without MAC_ACCUM_SATURATE_EN, 0xFF with it.
REQ-028 N=4, out_ready held low 5 cycles after completion with in_valid=1 -> in_ready = 0, out_valid and out_data stable, no input consumed; out_ready=1 -> next group starts from 0.
REQ-029 N=4, two transfers (0x010, 0x020) then clear asserted with in_valid=1 -> count = 0, that input not accumulated; next four transfers of 0x010 -> out_data = 0x04.
REQ-030 rst asserted in HOLD with out_ready=1 -> next cycle out_valid = 0, out_data = 0x00, in_ready = 1, count = 0.
REQ-031 N=1, in_valid continuously high, out_ready=1, inputs 0x0A0, 0x0B0 -> outputs 0x0A then 0x0B, one accept every 2 cycles.
